ascii_to_scancode_encoder: RTL
==============================

ASCII_TO_SCANCODE_ENCODER -- requirements
Module: ascii_to_scancode_encoder

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 0, idle cycles (range 0..255) inserted between consecutive bytes of one key sequence.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ascii_in  input  8  character to encode.
REQ-005 SHALL have port ascii_valid  input  1  ascii_in is valid.
REQ-006 SHALL have port ascii_ready  output  1  encoder can accept a character.
REQ-007 SHALL have port code_out  output  8  PS/2 Set 2 byte.
REQ-008 SHALL have port code_valid  output  1  code_out is valid.
REQ-009 SHALL have port code_ready  input  1  downstream accepts code_out.
REQ-010 SHALL have port unknown  output  1  one-cycle pulse for an unmapped character.

Function
REQ-011 SHALL map the ASCII codes as follows: '0'..'9' (30h..39h) -> 45,16,1E,26,25,2E,36,3D,3E,46h; 'A'..'F' (41h..46h) and 'a'..'f' (61h..66h) -> 1C,32,21,23,24,2Bh; CR (0Dh) -> 5Ah.
REQ-012 SHALL implement the FSM states IDLE, MAKE, GAP, BRK_PFX and BRK_CODE, with the state and mapped code held in registers.
REQ-013 SHALL drive ascii_ready=1 only in IDLE; a character is accepted on a cycle where ascii_valid and ascii_ready are both 1.
REQ-014 SHALL, for an accepted mapped character, latch the code and enter MAKE, with code_valid=1 and code_out equal to the make code on the next cycle (latency 1).
REQ-015 SHALL, for an accepted unmapped character, stay in IDLE and pulse unknown=1 for exactly the next cycle with no byte emitted; back-to-back accepts SHALL remain possible.
REQ-016 SHALL hold code_out and code_valid stable while code_valid=1 and code_ready=0; a byte transfers on a cycle where code_valid and code_ready are both 1.
REQ-017 SHALL, after each transfer that is not the last byte of a sequence, spend exactly GAP_CYCLES cycles in GAP with code_valid=0 before presenting the next byte; when GAP_CYCLES=0, the next byte SHALL be presented on the cycle after the transfer.
REQ-018 SHALL use a byte order MAKE(code), then BRK_PFX(F0h), then BRK_CODE(code) when break emission is enabled (REQ-024).
REQ-019 SHALL, after the last byte transfers, return to IDLE with code_valid=0 and ascii_ready=1 on the next cycle, and SHALL apply no gap after the last byte.
REQ-020 SHALL ignore ascii_valid outside IDLE, so characters are neither queued nor dropped silently, because ascii_ready=0.
REQ-021 SHALL keep the gap counter 8 bits wide, loaded with GAP_CYCLES and decremented to 0, with no wrap-around.

Reset
REQ-022 SHALL, while rst=1 and regardless of clk, force the following: state IDLE, ascii_ready=1, code_valid=0, code_out=00h, unknown=0, gap counter=0.
REQ-023 SHALL, when rst is asserted mid-sequence, abort the sequence with no further bytes; after release, the encoder waits in IDLE for a new character.

Configuration
REQ-024 SHALL have the macro ASCII_ENC_BREAK_EN: when defined, each mapped character emits 3 bytes (code, F0h, code); when undefined, each character emits only the make byte, and BRK_PFX and BRK_CODE are unreachable.

Verification
REQ-025 SHALL cover, with ASCII_ENC_BREAK_EN defined, GAP_CYCLES=0 and code_ready tied to 1, sending '5' (35h) -> code_out 2Eh, F0h, 2Eh on 3 consecutive cycles, with ascii_ready=1 again on the 4th cycle.
REQ-026 SHALL cover sending 'c' (63h) with code_ready=0 for 5 cycles -> code_out stays 21h with code_valid=1 for all 5 cycles, and 21h transfers once code_ready=1.
REQ-027 SHALL cover sending 'Z' (5Ah) -> unknown=1 for one cycle, no code_valid, and sending CR (0Dh) on the next cycle -> first byte 5Ah.
REQ-028 SHALL cover GAP_CYCLES=3 and sending '0' (30h) -> 45h, then 3 cycles with code_valid=0, then F0h, then 3 gap cycles, then 45h.
REQ-029 SHALL cover asserting rst after the F0h transfer for '9' (39h) -> no 46h break byte is emitted, and after release code_valid=0 and ascii_ready=1.
REQ-030 SHALL cover, with ASCII_ENC_BREAK_EN undefined, sending 'A' (41h) -> only 1Ch is emitted, with ascii_ready=1 on the cycle after the transfer.

Source files
------------

// File: rtl/ascii_to_scancode_encoder.sv
// ASCII to PS/2 Set 2 scancode encoder with a valid/ready byte stream output.
// Define ASCII_ENC_BREAK_EN to follow each make code with the F0h + code break sequence.
module ascii_to_scancode_encoder #(
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       unknown
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MAKE     = 3'd1,
    GAP      = 3'd2,
    BRK_PFX  = 3'd3,
    BRK_CODE = 3'd4
  } state_e;

  localparam logic [7:0] GAP_LD     = 8'(GAP_CYCLES);
  localparam logic [7:0] BRK_PREFIX = 8'hF0;

  // Returns {hit, make_code}; hit is 0 for characters without a key.
  function automatic logic [8:0] map_ascii(input logic [7:0] c);
    logic [8:0] r;
    case (c)
      8'h30:        r = {1'b1, 8'h45};
      8'h31:        r = {1'b1, 8'h16};
      8'h32:        r = {1'b1, 8'h1E};
      8'h33:        r = {1'b1, 8'h26};
      8'h34:        r = {1'b1, 8'h25};
      8'h35:        r = {1'b1, 8'h2E};
      8'h36:        r = {1'b1, 8'h36};
      8'h37:        r = {1'b1, 8'h3D};
      8'h38:        r = {1'b1, 8'h3E};
      8'h39:        r = {1'b1, 8'h46};
      8'h41, 8'h61: r = {1'b1, 8'h1C};
      8'h42, 8'h62: r = {1'b1, 8'h32};
      8'h43, 8'h63: r = {1'b1, 8'h21};
      8'h44, 8'h64: r = {1'b1, 8'h23};
      8'h45, 8'h65: r = {1'b1, 8'h24};
      8'h46, 8'h66: r = {1'b1, 8'h2B};
      8'h0D:        r = {1'b1, 8'h5A};
      default:      r = {1'b0, 8'h00};
    endcase
    return r;
  endfunction

  state_e     state_q;
  state_e     gap_next_q;
  logic [7:0] code_q;
  logic [7:0] out_q;
  logic       valid_q;
  logic       ready_q;
  logic       unknown_q;
  logic [7:0] gap_cnt_q;

  logic [8:0] map_s;
  logic       accept_s;
  logic       xfer_s;

  always_comb begin
    map_s    = map_ascii(ascii_in);
    accept_s = ascii_valid & ready_q;
    xfer_s   = valid_q & code_ready;
  end

  // Sequencer: outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_next_q <= BRK_PFX;
      code_q     <= 8'h00;
      out_q      <= 8'h00;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      unknown_q  <= 1'b0;
      gap_cnt_q  <= 8'h00;
    end else begin
      unknown_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            if (map_s[8]) begin
              code_q  <= map_s[7:0];
              out_q   <= map_s[7:0];
              valid_q <= 1'b1;
              ready_q <= 1'b0;
              state_q <= MAKE;
            end else begin
              unknown_q <= 1'b1;
            end
          end
        end
        MAKE: begin
          if (xfer_s) begin
`ifdef ASCII_ENC_BREAK_EN
            if (GAP_LD == 8'd0) begin
              out_q   <= BRK_PREFIX;
              state_q <= BRK_PFX;
            end else begin
              valid_q    <= 1'b0;
              gap_cnt_q  <= GAP_LD;
              gap_next_q <= BRK_PFX;
              state_q    <= GAP;
            end
`else
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
`endif
          end
        end
        GAP: begin
          // The last gap cycle presents the pending byte directly, giving exactly GAP_LD idle cycles.
          if (gap_cnt_q <= 8'd1) begin
            gap_cnt_q <= 8'd0;
            valid_q   <= 1'b1;
            out_q     <= (gap_next_q == BRK_PFX) ? BRK_PREFIX : code_q;
            state_q   <= gap_next_q;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        BRK_PFX: begin
          if (xfer_s) begin
            if (GAP_LD == 8'd0) begin
              out_q   <= code_q;
              state_q <= BRK_CODE;
            end else begin
              valid_q    <= 1'b0;
              gap_cnt_q  <= GAP_LD;
              gap_next_q <= BRK_CODE;
              state_q    <= GAP;
            end
          end
        end
        BRK_CODE: begin
          if (xfer_s) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q   <= 1'b0;
          ready_q   <= 1'b1;
          gap_cnt_q <= 8'h00;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ascii_ready = ready_q;
  assign code_out    = out_q;
  assign code_valid  = valid_q;
  assign unknown     = unknown_q;

endmodule
